aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the AES-128 encryption core. It owns the 16×8 state register and steps it through the external combinational round datapath (subbytes → shiftrows → mixcolumns → addroundkey) for the initial key addition plus rounds 1–10. It drives the round number to the key schedule, bypasses mixcolumns in round 10, and presents the ciphertext through a valid/ack handshake. It sits between the block-level input interface and the round datapath.

## Interface
- NR, 10, number of full rounds; fixed at 10 for AES-128, so the round counter is 4 bits.
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to encrypt `plaintext`; accepted only when `ready`=1.
- plaintext  input  [15:0][7:0]  input block; sampled on the acceptance edge.
- ready  output  1  combinational; `(fsm==IDLE) | (fsm==DONE & out_ack)`.
- round_num  output  4  current round, 0–10; drives the key-schedule round-key select.
- ark_only  output  1  high while `round_num`==0; the datapath performs only addroundkey.
- mix_en  output  1  high for `round_num` 1–9, low for 0 and 10.
- state_q  output  [15:0][7:0]  registered state; feeds the datapath.
- round_out  input  [15:0][7:0]  datapath result for `state_q`/`round_num`.
- out_valid  output  1  ciphertext valid; high in DONE.
- out_ack  input  1  consumer accepts the ciphertext.
- ciphertext  output  [15:0][7:0]  equals `state_q` when `out_valid`=1.
- busy  output  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if `start`=1, then `state_q`←`plaintext`, `round_num`←0, and the FSM moves to RUN. Otherwise all registers hold.
- RUN, per advancing edge: `state_q`←`round_out`.
  - If `round_num`<10: `round_num`←`round_num`+1.
  - If `round_num`==10: go to DONE and hold `round_num`=10.
- DONE: `out_valid`=1 and `state_q` holds.
  - `out_ack`=1 with `start`=0: go to IDLE and set `round_num`←0.
  - `out_ack`=1 with `start`=1: back-to-back acceptance. Load `plaintext`, set `round_num`←0, go to RUN.
  - `out_ack`=0: stay in DONE. `start` is ignored.
- `start` is ignored in RUN. There is no abort.
- `round_num` never exceeds 10 and never wraps.
- `out_ack` outside DONE is ignored.

## Timing
- Reset values (asynchronous): FSM=IDLE, `state_q`=0, `round_num`=0, `out_valid`=0, `busy`=0. With `round_num`=0, `ark_only`=1 and `mix_en`=0; these outputs are don't-care in IDLE.
- Reset asserted mid-RUN or in DONE: all registers clear immediately. The in-flight block is discarded and no `out_valid` is produced.
- All outputs except `ready` are decoded from registers only.
- Latency without stalls: on acceptance edge E0 the FSM enters RUN. Edges E1–E11 capture rounds 0–10. `out_valid` rises after E11, i.e. 11 cycles after acceptance.
- Throughput: one block per 12 cycles with `out_ack` held high. Back-to-back handover leaves no idle cycle.
- `round_out` must settle within one clock. The datapath is purely combinational.

## Configuration
- `AES_KEY_STALL_EN` defined:
  - Adds port `key_valid`, input, 1 bit.
  - In RUN, an edge advances (captures `round_out` and increments `round_num`) only when `key_valid`=1. When `key_valid`=0, `state_q`, `round_num` and the FSM hold, and `busy` stays 1.
  - `key_valid` is ignored in IDLE and DONE.
- `AES_KEY_STALL_EN` undefined: the `key_valid` port is absent and RUN advances on every edge.

## Test plan
- FIPS-197 C.1: key 000102…0f, `plaintext`=00112233445566778899aabbccddeeff, `start` pulse. Require `out_valid` exactly 11 cycles after acceptance, `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a, `round_num` sequence 0,1,…,10, `mix_en` low only at rounds 0 and 10.
- Hold `out_ack`=0 for 5 cycles in DONE while pulsing `start`. Require `ciphertext` stable, `ready`=0 and no reload. Then assert `out_ack`: require FSM=IDLE on the next cycle.
- `start` and `out_ack` high together in DONE with a second plaintext. Require immediate RUN with `round_num`=0. The second ciphertext is valid 11 cycles later.
- Assert `reset` at `round_num`=5. Require `state_q`=0, `busy`=0 and `out_valid`=0 before the next edge. Starting a new block afterwards yields correct ciphertext.
- Pulse `start` during RUN at round 3. Require no effect on `round_num` progression or result.
- With `AES_KEY_STALL_EN`, drive `key_valid`=0 for 3 cycles at round 4. Require `round_num` to stay at 4, `state_q` to hold, latency to become 14 cycles, and the ciphertext to be unchanged.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer.
// Owns the 128-bit state register and walks it through the external
// combinational round datapath: the initial addroundkey (round 0), then
// full rounds 1..9 and the final round 10 without mixcolumns. The result
// is offered through a valid/ack handshake. A block can be handed over
// back-to-back, so the next block is accepted on the same edge as the ack.
// Optional feature macro: AES_KEY_STALL_EN adds the key_valid input. When
// key_valid is low, RUN holds its state and round number.
module aes_round_ctrl (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0][7:0] plaintext,
`ifdef AES_KEY_STALL_EN
    input  logic             key_valid,
`endif
    output logic             ready,
    output logic [3:0]       round_num,
    output logic             ark_only,
    output logic             mix_en,
    output logic [15:0][7:0] state_q,
    input  logic [15:0][7:0] round_out,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [15:0][7:0] ciphertext,
    output logic             busy
);

    localparam int unsigned NR        = 10;
    localparam logic [3:0]  LastRound = 4'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t             r_fsm;
    fsm_t             w_fsmNext;
    logic [3:0]       r_round;
    logic [3:0]       w_roundNext;
    logic [15:0][7:0] r_state;
    logic [15:0][7:0] w_stateNext;
    logic             w_advance;

`ifdef AES_KEY_STALL_EN
    assign w_advance = key_valid;
`else
    assign w_advance = 1'b1;
`endif

    // State, round counter and block register; reset discards any in-flight block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm   <= IDLE;
            r_round <= 4'd0;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsmNext;
            r_round <= w_roundNext;
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: load on acceptance, step one round per advancing edge, hand off in DONE.
    always_comb begin
        w_fsmNext   = r_fsm;
        w_roundNext = r_round;
        w_stateNext = r_state;
        case (r_fsm)
            IDLE: begin
                if (start) begin
                    w_fsmNext   = RUN;
                    w_roundNext = 4'd0;
                    w_stateNext = plaintext;
                end
            end
            RUN: begin
                if (w_advance) begin
                    w_stateNext = round_out;
                    if (r_round == LastRound) begin
                        w_fsmNext = DONE;
                    end else begin
                        w_roundNext = r_round + 4'd1;
                    end
                end
            end
            DONE: begin
                if (out_ack) begin
                    w_roundNext = 4'd0;
                    if (start) begin
                        w_fsmNext   = RUN;
                        w_stateNext = plaintext;
                    end else begin
                        w_fsmNext = IDLE;
                    end
                end
            end
            default: begin
                w_fsmNext   = IDLE;
                w_roundNext = 4'd0;
            end
        endcase
    end

    // ready is the only output that depends on an input: in DONE, an ack frees the slot within the same cycle.
    assign ready      = (r_fsm == IDLE) | ((r_fsm == DONE) & out_ack);

    assign round_num  = r_round;
    assign ark_only   = (r_round == 4'd0);
    assign mix_en     = (r_round != 4'd0) && (r_round != LastRound);
    assign state_q    = r_state;
    assign ciphertext = r_state;
    assign out_valid  = (r_fsm == DONE);
    assign busy       = (r_fsm == RUN);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: self-checking bench for aes_round_ctrl.
// The bench supplies the combinational AES round datapath itself. It drives
// that datapath from the DUT's state_q, round_num, ark_only and mix_en. It
// checks the outputs against fixed FIPS-197 vectors and against a full AES-128
// encryption model. The model also predicts the cycle at which out_valid rises.
// Define AES_KEY_STALL_EN to also exercise the key_valid stall path.
module tb_aes_round_ctrl;

    localparam int MaxWait = 80;
    localparam int NRand   = 24;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [15:0][7:0] plaintext;
    logic             ready;
    logic [3:0]       round_num;
    logic             ark_only;
    logic             mix_en;
    logic [15:0][7:0] state_q;
    logic [15:0][7:0] round_out;
    logic             out_valid;
    logic             out_ack;
    logic [15:0][7:0] ciphertext;
    logic             busy;
`ifdef AES_KEY_STALL_EN
    logic             key_valid;
`endif

    logic [127:0] tbKey;
    int           nCompared;
    int           nMismatched;
    vec_t         vecs [3];

    aes_round_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
`ifdef AES_KEY_STALL_EN
        .key_valid  (key_valid),
`endif
        .ready      (ready),
        .round_num  (round_num),
        .ark_only   (ark_only),
        .mix_en     (mix_en),
        .state_q    (state_q),
        .round_out  (round_out),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES-128 arithmetic ----------------
    // Block byte i (in FIPS input order) lives at bits [127-8*i -: 8].

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from first principles: the GF(2^8) inverse (b^254), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = b;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixCols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-8*(4*c)   -: 8];
            a1 = s[127-8*(4*c+1) -: 8];
            a2 = s[127-8*(4*c+2) -: 8];
            a3 = s[127-8*(4*c+3) -: 8];
            o[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] roundKey(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Reference: a whole AES-128 encryption in one call.
    function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s;
        s = pt ^ roundKey(key, 0);
        for (int r = 1; r <= 10; r++) begin
            s = subShift(s);
            if (r < 10) s = mixCols(s);
            s = s ^ roundKey(key, r);
        end
        return s;
    endfunction

    // External datapath model, steered by the controller's decode outputs.
    function automatic logic [127:0] dpRound(input logic [127:0] s, input logic [3:0] rn,
                                             input logic ark, input logic mix,
                                             input logic [127:0] key);
        logic [127:0] rk;
        logic [127:0] t;
        if (rn > 4'd10) return '0;
        rk = roundKey(key, int'(rn));
        if (ark) return s ^ rk;
        t = subShift(s);
        if (mix) t = mixCols(t);
        return t ^ rk;
    endfunction

    assign round_out = dpRound(state_q, round_num, ark_only, mix_en, tbKey);

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- bench tasks ----------------

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [127:0] p, input logic a);
        start     = s;
        plaintext = p;
        out_ack   = a;
    endtask

    task automatic setKv(input logic v);
`ifdef AES_KEY_STALL_EN
        key_valid = v;
`else
        if (v !== 1'b1) $display("[TB] key_valid stall requested without AES_KEY_STALL_EN");
`endif
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic acceptBlock(input logic [127:0] key, input logic [127:0] pt);
        checkOutput("ready_before_start", 128'(ready), 128'd1);
        tbKey = key;
        applyStimulus(1'b1, pt, 1'b0);
        stepClk();
        applyStimulus(1'b0, pt, 1'b0);
        checkOutput("accept_busy", 128'(busy), 128'd1);
        checkOutput("accept_round", 128'(round_num), 128'd0);
        checkOutput("accept_state", state_q, pt);
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < MaxWait) begin
            stepClk();
            cycles++;
        end
        if (cycles >= MaxWait) checkOutput("wait_out_valid_timeout", 128'(out_valid), 128'd1);
    endtask

    task automatic ackIdle();
        applyStimulus(1'b0, plaintext, 1'b1);
        #1;
        checkOutput("ack_ready", 128'(ready), 128'd1);
        stepClk();
        applyStimulus(1'b0, plaintext, 1'b0);
        checkOutput("idle_valid", 128'(out_valid), 128'd0);
        checkOutput("idle_busy", 128'(busy), 128'd0);
        checkOutput("idle_round", 128'(round_num), 128'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time limit expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int           lat;
        int           lat2;
        int           edges;
        int           adv;
        logic         kv;
        logic [127:0] held;
        logic [127:0] rKey;
        logic [127:0] rPt;
        logic [127:0] expCt;

        nCompared   = 0;
        nMismatched = 0;

        vecs[0].key = 128'h000102030405060708090a0b0c0d0e0f;
        vecs[0].pt  = 128'h00112233445566778899aabbccddeeff;
        vecs[0].ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vecs[1].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vecs[1].pt  = 128'h3243f6a8885a308d313198a2e0370734;
        vecs[1].ct  = 128'h3925841d02dc09fbdc118597196a0b32;
        vecs[2].key = 128'h0;
        vecs[2].pt  = 128'h0;
        vecs[2].ct  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

        // Reset values
        reset = 1'b1;
        tbKey = '0;
        applyStimulus(1'b0, 128'h0, 1'b0);
        setKv(1'b1);
        #2;
        checkOutput("rst_state", state_q, 128'h0);
        checkOutput("rst_round", 128'(round_num), 128'd0);
        checkOutput("rst_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_ready", 128'(ready), 128'd1);
        checkOutput("rst_ark_only", 128'(ark_only), 128'd1);
        checkOutput("rst_mix_en", 128'(mix_en), 128'd0);
        stepClk();
        stepClk();
        reset = 1'b0;
        stepClk();

        // FIPS-197 C.1 with a per-cycle trace of the round controls
        acceptBlock(vecs[0].key, vecs[0].pt);
        for (int r = 0; r <= 10; r++) begin
            checkOutput("c1_round", 128'(round_num), 128'(r));
            checkOutput("c1_mix_en", 128'(mix_en), 128'(r >= 1 && r <= 9));
            checkOutput("c1_ark_only", 128'(ark_only), 128'(r == 0));
            checkOutput("c1_busy", 128'(busy), 128'd1);
            checkOutput("c1_valid_early", 128'(out_valid), 128'd0);
            stepClk();
        end
        checkOutput("c1_valid", 128'(out_valid), 128'd1);
        checkOutput("c1_ct", ciphertext, vecs[0].ct);
        checkOutput("c1_busy_done", 128'(busy), 128'd0);
        checkOutput("c1_round_done", 128'(round_num), 128'd10);
        ackIdle();

        // Known-answer table
        for (int i = 0; i < 3; i++) begin
            acceptBlock(vecs[i].key, vecs[i].pt);
            waitDone(lat);
            checkOutput("tbl_latency", 128'(lat), 128'd11);
            checkOutput("tbl_ct", ciphertext, vecs[i].ct);
            ackIdle();
        end

        // DONE held without ack while start pulses: no reload, output stable
        acceptBlock(vecs[1].key, vecs[1].pt);
        waitDone(lat);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i % 2 == 0, rand128(), 1'b0);
            #1;
            checkOutput("hold_ready", 128'(ready), 128'd0);
            stepClk();
            checkOutput("hold_ct", ciphertext, vecs[1].ct);
            checkOutput("hold_valid", 128'(out_valid), 128'd1);
            checkOutput("hold_round", 128'(round_num), 128'd10);
            checkOutput("hold_busy", 128'(busy), 128'd0);
        end
        ackIdle();
        checkOutput("hold_idle_ready", 128'(ready), 128'd1);

        // Back-to-back handover: ack and start on the same edge
        acceptBlock(vecs[0].key, vecs[0].pt);
        waitDone(lat);
        checkOutput("b2b_first_ct", ciphertext, vecs[0].ct);
        tbKey = vecs[1].key;
        applyStimulus(1'b1, vecs[1].pt, 1'b1);
        #1;
        checkOutput("b2b_ready", 128'(ready), 128'd1);
        stepClk();
        applyStimulus(1'b0, vecs[1].pt, 1'b0);
        checkOutput("b2b_busy", 128'(busy), 128'd1);
        checkOutput("b2b_round", 128'(round_num), 128'd0);
        checkOutput("b2b_valid", 128'(out_valid), 128'd0);
        checkOutput("b2b_state", state_q, vecs[1].pt);
        waitDone(lat);
        checkOutput("b2b_latency", 128'(lat), 128'd11);
        checkOutput("b2b_ct", ciphertext, vecs[1].ct);
        ackIdle();

        // Reset at round 5 clears everything asynchronously
        acceptBlock(vecs[2].key, vecs[2].pt);
        repeat (5) stepClk();
        checkOutput("mid_rst_round_pre", 128'(round_num), 128'd5);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_state", state_q, 128'h0);
        checkOutput("mid_rst_busy", 128'(busy), 128'd0);
        checkOutput("mid_rst_valid", 128'(out_valid), 128'd0);
        checkOutput("mid_rst_round", 128'(round_num), 128'd0);
        stepClk();
        reset = 1'b0;
        stepClk();
        checkOutput("post_rst_valid", 128'(out_valid), 128'd0);
        acceptBlock(vecs[0].key, vecs[0].pt);
        waitDone(lat);
        checkOutput("post_rst_latency", 128'(lat), 128'd11);
        checkOutput("post_rst_ct", ciphertext, vecs[0].ct);
        ackIdle();

        // start pulse during RUN at round 3 has no effect
        acceptBlock(vecs[1].key, vecs[1].pt);
        repeat (3) stepClk();
        checkOutput("run_start_round_pre", 128'(round_num), 128'd3);
        applyStimulus(1'b1, rand128(), 1'b0);
        stepClk();
        applyStimulus(1'b0, plaintext, 1'b0);
        checkOutput("run_start_round_post", 128'(round_num), 128'd4);
        checkOutput("run_start_busy", 128'(busy), 128'd1);
        waitDone(lat2);
        checkOutput("run_start_latency", 128'(4 + lat2), 128'd11);
        checkOutput("run_start_ct", ciphertext, vecs[1].ct);
        ackIdle();

`ifdef AES_KEY_STALL_EN
        // key_valid low for 3 cycles at round 4 stretches latency to 14
        acceptBlock(vecs[0].key, vecs[0].pt);
        repeat (4) stepClk();
        checkOutput("stall_round_pre", 128'(round_num), 128'd4);
        held = state_q;
        setKv(1'b0);
        for (int i = 0; i < 3; i++) begin
            stepClk();
            checkOutput("stall_round", 128'(round_num), 128'd4);
            checkOutput("stall_state", state_q, held);
            checkOutput("stall_busy", 128'(busy), 128'd1);
        end
        setKv(1'b1);
        waitDone(lat);
        checkOutput("stall_latency", 128'(7 + lat), 128'd14);
        checkOutput("stall_ct", ciphertext, vecs[0].ct);
        ackIdle();
`endif

        // Randomized blocks against the encryption model
        rKey = rand128();
        rPt  = rand128();
        for (int b = 0; b < NRand; b++) begin
            if (b == 0 || !busy) begin
                repeat ($urandom_range(0, 2)) begin
                    applyStimulus(1'b0, rand128(), 1'($urandom % 2));
                    stepClk();
                    checkOutput("rnd_idle_valid", 128'(out_valid), 128'd0);
                end
                applyStimulus(1'b0, plaintext, 1'b0);
                rKey = rand128();
                rPt  = rand128();
                acceptBlock(rKey, rPt);
            end
            expCt = aesEncrypt(rPt, rKey);
            adv   = 0;
            edges = 0;
            while (adv < 11 && edges < MaxWait) begin
`ifdef AES_KEY_STALL_EN
                kv = ($urandom_range(0, 3) != 0);
`else
                kv = 1'b1;
`endif
                setKv(kv);
                applyStimulus($urandom_range(0, 4) == 0, rand128(), 1'($urandom % 2));
                stepClk();
                edges++;
                if (kv) adv++;
                checkOutput("rnd_valid", 128'(out_valid), 128'(adv == 11));
            end
            setKv(1'b1);
            applyStimulus(1'b0, rand128(), 1'b0);
            checkOutput("rnd_ct", ciphertext, expCt);
            repeat ($urandom_range(0, 3)) begin
                applyStimulus(1'($urandom % 2), rand128(), 1'b0);
                setKv(1'($urandom % 2));
                stepClk();
                checkOutput("rnd_wait_ct", ciphertext, expCt);
                checkOutput("rnd_wait_valid", 128'(out_valid), 128'd1);
            end
            setKv(1'b1);
            if (b < NRand - 1 && ($urandom % 2) == 1) begin
                rKey  = rand128();
                rPt   = rand128();
                tbKey = rKey;
                applyStimulus(1'b1, rPt, 1'b1);
                stepClk();
                applyStimulus(1'b0, rPt, 1'b0);
                checkOutput("rnd_b2b_busy", 128'(busy), 128'd1);
                checkOutput("rnd_b2b_round", 128'(round_num), 128'd0);
                checkOutput("rnd_b2b_state", state_q, rPt);
            end else begin
                ackIdle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
